// File: rtl/armleocpu_mul_unit.sv
// armleocpu_mul_unit: RV32M multiply front/back end around an external
// 32x32=64 unsigned shift-add multiplier.
// Operands are turned into magnitudes on accept, the multiplier is started
// with a single pulse, and the 64-bit product gets its sign back before the
// requested 32-bit half goes to execute.
// Optional build macro: ARMLEOCPU_MUL_ZERO_BYPASS_EN (a zero operand skips
// the multiplier and answers 0 one cycle after accept).
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | start pulse on mul_valid
// WAIT  | waiting for the multiplier done pulse
// RESP  | resp_valid pulse to execute
module armleocpu_mul_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        resp_valid,
    output logic [31:0] resp_result,
    output logic        resp_illegal,
    output logic        mul_valid,
    output logic [31:0] mul_factor0,
    output logic [31:0] mul_factor1,
    input  logic        mul_ready,
    input  logic [63:0] mul_result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_result_q, resp_result_d;
    logic        resp_illegal_q, resp_illegal_d;
    logic        mul_valid_q, mul_valid_d;
    logic [31:0] factor0_q, factor0_d;
    logic [31:0] factor1_q, factor1_d;
    logic [1:0]  funct3_q, funct3_d;
    logic        neg_q, neg_d;

    logic        accept;
    logic        sign1;
    logic        sign2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        zero_bypass;
    logic [63:0] product;

    // operand signedness and magnitudes seen on the request bus
    assign accept = req_valid & req_ready_q;
    assign sign1  = ((req_funct3 == 3'b001) | (req_funct3 == 3'b010)) & req_rs1[31];
    assign sign2  = (req_funct3 == 3'b001) & req_rs2[31];
    assign mag1   = sign1 ? (~req_rs1 + 32'd1) : req_rs1;
    assign mag2   = sign2 ? (~req_rs2 + 32'd1) : req_rs2;
    assign product = neg_q ? (~mul_result + 64'd1) : mul_result;

`ifdef ARMLEOCPU_MUL_ZERO_BYPASS_EN
    assign zero_bypass = (mag1 == 32'd0) | (mag2 == 32'd0);
`else
    assign zero_bypass = 1'b0;
`endif

    // next-state and next-output computation
    always_comb begin
        state_d        = state_q;
        resp_valid_d   = 1'b0;
        mul_valid_d    = 1'b0;
        resp_result_d  = resp_result_q;
        resp_illegal_d = resp_illegal_q;
        factor0_d      = factor0_q;
        factor1_d      = factor1_q;
        funct3_d       = funct3_q;
        neg_d          = neg_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = req_funct3[1:0];
                    if (req_funct3[2]) begin
                        // illegal: answer immediately, leave the multiplier alone
                        state_d        = S_RESP;
                        resp_valid_d   = 1'b1;
                        resp_illegal_d = 1'b1;
                        resp_result_d  = 32'd0;
                    end else begin
                        factor0_d      = mag1;
                        factor1_d      = mag2;
                        neg_d          = sign1 ^ sign2;
                        resp_illegal_d = 1'b0;
                        if (zero_bypass) begin
                            state_d       = S_RESP;
                            resp_valid_d  = 1'b1;
                            resp_result_d = 32'd0;
                        end else begin
                            state_d     = S_ISSUE;
                            mul_valid_d = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_ready) begin
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_result_d = (funct3_q == 2'b00) ? product[31:0] : product[63:32];
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ready is registered so it reads 0 during reset and comes back with IDLE
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
    end

    // state and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            req_ready_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_result_q  <= 32'd0;
            resp_illegal_q <= 1'b0;
            mul_valid_q    <= 1'b0;
            factor0_q      <= 32'd0;
            factor1_q      <= 32'd0;
            funct3_q       <= 2'd0;
            neg_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_result_q  <= resp_result_d;
            resp_illegal_q <= resp_illegal_d;
            mul_valid_q    <= mul_valid_d;
            factor0_q      <= factor0_d;
            factor1_q      <= factor1_d;
            funct3_q       <= funct3_d;
            neg_q          <= neg_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_result  = resp_result_q;
    assign resp_illegal = resp_illegal_q;
    assign mul_valid    = mul_valid_q;
    assign mul_factor0  = factor0_q;
    assign mul_factor1  = factor1_q;

endmodule
